tank_sprite_renderer: RTL and testbench



---
 rtl/tank_sprite_renderer.sv | 148 ++++++++++++++
 tb/tb_tank_sprite_renderer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_sprite_renderer.sv
// Two-stage pixel pipeline that overlays one 16x16 tank icon on the video stream.
// Optional hit-blink support is compiled in with `SPRITE_FLASH_EN.
module tank_sprite_renderer #(
    parameter int VERT_PIXELS  = 768,
    parameter int FLASH_FRAMES = 16
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [10:0] pixel_row,
    input  logic [10:0] pixel_column,
    input  logic        video_on,
    input  logic        horiz_sync,
    input  logic        vert_sync,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic [1:0]  orient,
    input  logic        pos_valid,
    output logic        pos_ack,
    input  logic        hit,
    output logic [1:0]  icon,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        video_on_out,
    output logic        frame_tick
);

    logic        fb;
    logic [10:0] x_act, y_act;
    logic [1:0]  or_act;
    logic        act_en;
    logic        blank;

    assign fb = (pixel_row == 11'(VERT_PIXELS)) && (pixel_column == 11'd0);

    // Position is only swapped at the frame boundary so the sprite never tears.
    always_ff @(posedge clock) begin
        if (rst) begin
            x_act      <= '0;
            y_act      <= '0;
            or_act     <= '0;
            act_en     <= 1'b0;
            pos_ack    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= fb;
            pos_ack    <= fb && pos_valid;
            if (fb && pos_valid) begin
                x_act  <= pos_x;
                y_act  <= pos_y;
                or_act <= orient;
                act_en <= 1'b1;
            end
        end
    end

`ifdef SPRITE_FLASH_EN
    logic [4:0] flash_cnt;

    always_ff @(posedge clock) begin
        if (rst)
            flash_cnt <= '0;
        else if (hit)
            flash_cnt <= 5'(FLASH_FRAMES);
        else if (fb && flash_cnt != 5'd0)
            flash_cnt <= flash_cnt - 5'd1;
    end

    assign blank = (flash_cnt != 5'd0) && flash_cnt[1];
`else
    logic unused_hit;
    assign unused_hit = hit;
    assign blank      = 1'b0;
`endif

    // Stage 1: sprite-relative coordinates with unsigned wrap.
    logic [10:0] dr, dc;
    logic        in_box;
    logic [3:0]  s1_r, s1_c;
    logic [1:0]  s1_or;
    logic        s1_in, s1_hs, s1_vs, s1_vo, s1_blank;

    assign dr     = pixel_row - y_act;
    assign dc     = pixel_column - x_act;
    assign in_box = act_en && video_on && (dr < 11'd16) && (dc < 11'd16);

    always_ff @(posedge clock) begin
        if (rst) begin
            s1_r     <= '0;
            s1_c     <= '0;
            s1_or    <= '0;
            s1_in    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_vo    <= 1'b0;
            s1_blank <= 1'b0;
        end else begin
            s1_r     <= dr[3:0];
            s1_c     <= dc[3:0];
            s1_or    <= or_act;
            s1_in    <= in_box;
            s1_hs    <= horiz_sync;
            s1_vs    <= vert_sync;
            s1_vo    <= video_on;
            s1_blank <= blank;
        end
    end

    // Stage 2: rotate into the up-facing base frame, then look up the bitmap.
    logic [3:0] rp, cp;
    logic [1:0] code;

    always_comb begin
        rp = s1_r;
        cp = s1_c;
        case (s1_or)
            2'd1:    begin rp = ~s1_c; cp = s1_r;  end
            2'd2:    begin rp = ~s1_r; cp = ~s1_c; end
            2'd3:    begin rp = s1_c;  cp = ~s1_r; end
            default: begin rp = s1_r;  cp = s1_c;  end
        endcase
    end

    always_comb begin
        code = 2'b00;
        if ((cp == 4'd3 || cp == 4'd4 || cp == 4'd11 || cp == 4'd12) &&
            rp >= 4'd2 && rp <= 4'd13)
            code = 2'b11;
        else if ((cp == 4'd7 || cp == 4'd8) && rp <= 4'd7)
            code = 2'b10;
        else if (cp >= 4'd5 && cp <= 4'd10 && rp >= 4'd2 && rp <= 4'd13)
            code = 2'b01;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            icon         <= 2'b00;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            video_on_out <= 1'b0;
        end else begin
            icon         <= (s1_in && !s1_blank) ? code : 2'b00;
            hsync_out    <= s1_hs;
            vsync_out    <= s1_vs;
            video_on_out <= s1_vo;
        end
    end

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Randomized bench for tank_sprite_renderer against a rotated-bitmap reference model.
// Honors `SPRITE_FLASH_EN to model hit blinking.
module tb_tank_sprite_renderer;

    localparam int VP    = 768;
    localparam int FLASH = 16;

    logic        clock = 1'b0;
    logic        rst;
    logic [10:0] pixel_row, pixel_column, pos_x, pos_y;
    logic        video_on, horiz_sync, vert_sync, pos_valid, hit;
    logic [1:0]  orient;
    logic        pos_ack, hsync_out, vsync_out, video_on_out, frame_tick;
    logic [1:0]  icon;

    always #20 clock = ~clock;

    tank_sprite_renderer #(.VERT_PIXELS(VP), .FLASH_FRAMES(FLASH)) dut (
        .clock(clock), .rst(rst),
        .pixel_row(pixel_row), .pixel_column(pixel_column),
        .video_on(video_on), .horiz_sync(horiz_sync), .vert_sync(vert_sync),
        .pos_x(pos_x), .pos_y(pos_y), .orient(orient),
        .pos_valid(pos_valid), .pos_ack(pos_ack), .hit(hit),
        .icon(icon), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .video_on_out(video_on_out), .frame_tick(frame_tick)
    );

    typedef struct {
        logic [1:0] icon;
        logic       hs, vs, vo;
    } exp_t;

    exp_t q[$];
    int   rot[4][16][16];
    int   m_x, m_y, m_or, m_flash;
    bit   m_en;
    int   n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Up-facing bitmap, then each heading is a further clockwise quarter turn.
    task automatic build_tables();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                if ((c == 3 || c == 4 || c == 11 || c == 12) && r >= 2 && r <= 13)
                    rot[0][r][c] = 3;
                else if ((c == 7 || c == 8) && r <= 7)
                    rot[0][r][c] = 2;
                else if (c >= 5 && c <= 10 && r >= 2 && r <= 13)
                    rot[0][r][c] = 1;
                else
                    rot[0][r][c] = 0;
            end
        for (int k = 1; k < 4; k++)
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    rot[k][r][c] = rot[k-1][15-c][r];
    endtask

    task automatic do_reset();
        exp_t z;
        rst          = 1'b1;
        horiz_sync   = 1'b1;
        vert_sync    = 1'b1;
        video_on     = 1'b1;
        @(posedge clock); #1;
        chk("rst_icon", 16'(icon), 16'd0);
        chk("rst_hs", 16'(hsync_out), 16'd0);
        chk("rst_vs", 16'(vsync_out), 16'd0);
        chk("rst_vo", 16'(video_on_out), 16'd0);
        chk("rst_ack", 16'(pos_ack), 16'd0);
        chk("rst_tick", 16'(frame_tick), 16'd0);
        rst     = 1'b0;
        m_x     = 0;
        m_y     = 0;
        m_or    = 0;
        m_en    = 1'b0;
        m_flash = 0;
        z = '{icon: 2'b00, hs: 1'b0, vs: 1'b0, vo: 1'b0};
        q.delete();
        q.push_back(z);
    endtask

    // One pixel clock: drive inputs, predict, clock, check.
    task automatic step(input logic [10:0] r, input logic [10:0] c, input logic v);
        exp_t e;
        int   dr, dc;
        bit   fb, exp_ack;
        pixel_row    = r;
        pixel_column = c;
        video_on     = v;
        horiz_sync   = 1'($urandom);
        vert_sync    = 1'($urandom);
        dr = (int'(r) - m_y) & 2047;
        dc = (int'(c) - m_x) & 2047;
        e.icon = 2'b00;
        if (m_en && v && dr < 16 && dc < 16) e.icon = 2'(rot[m_or][dr][dc]);
`ifdef SPRITE_FLASH_EN
        if (m_flash != 0 && (m_flash % 4) >= 2) e.icon = 2'b00;
`endif
        e.hs = horiz_sync;
        e.vs = vert_sync;
        e.vo = v;
        q.push_back(e);
        fb      = (r == 11'(VP)) && (c == 11'd0);
        exp_ack = fb && pos_valid;
        if (exp_ack) begin
            m_x  = int'(pos_x);
            m_y  = int'(pos_y);
            m_or = int'(orient);
            m_en = 1'b1;
        end
`ifdef SPRITE_FLASH_EN
        if (hit) m_flash = FLASH;
        else if (fb && m_flash > 0) m_flash--;
`endif
        @(posedge clock); #1;
        chk("ack", 16'(pos_ack), 16'(exp_ack));
        chk("tick", 16'(frame_tick), 16'(fb));
        e = q.pop_front();
        chk("icon", 16'(icon), 16'(e.icon));
        chk("hsync", 16'(hsync_out), 16'(e.hs));
        chk("vsync", 16'(vsync_out), 16'(e.vs));
        chk("vid", 16'(video_on_out), 16'(e.vo));
        if (pos_ack) pos_valid = 1'b0;
        hit = 1'b0;
    endtask

    task automatic request(input int x, input int y, input int o);
        pos_x     = 11'(x);
        pos_y     = 11'(y);
        orient    = 2'(o);
        pos_valid = 1'b1;
    endtask

    task automatic rand_step();
        int sel;
        logic [10:0] r, c;
        if (!pos_valid && $urandom_range(0, 79) == 0) begin
            if ($urandom_range(0, 3) == 0)
                request(1008 + $urandom_range(0, 15), 752 + $urandom_range(0, 15), $urandom_range(0, 3));
            else
                request($urandom_range(0, 1023), $urandom_range(0, 767), $urandom_range(0, 3));
        end else if (pos_valid && $urandom_range(0, 149) == 0)
            pos_valid = 1'b0;
        hit = ($urandom_range(0, 299) == 0);
        sel = $urandom_range(0, 99);
        if (sel < 2) begin
            r = 11'(VP);
            c = 11'd0;
        end else if (sel < 65) begin
            r = 11'(m_y + $urandom_range(0, 19) - 2);
            c = 11'(m_x + $urandom_range(0, 19) - 2);
        end else begin
            r = 11'($urandom_range(0, 805));
            c = 11'($urandom_range(0, 1055));
        end
        step(r, c, $urandom_range(0, 9) != 0);
    endtask

    initial begin
        build_tables();
        pos_valid = 1'b0;
        hit       = 1'b0;
        pos_x     = '0;
        pos_y     = '0;
        orient    = '0;
        pixel_row = '0;
        pixel_column = '0;
        do_reset();

        // No request yet: nothing is drawn anywhere.
        repeat (300) step(11'($urandom_range(0, 805)), 11'($urandom_range(0, 1055)), 1'b1);
        step(11'd0, 11'd0, 1'b1);
        chk("blank", 16'(icon), 16'd0);

        // Heading up at (100, 50).
        request(100, 50, 0);
        step(11'd700, 11'd5, 1'b0);
        chk("no_early_ack", 16'(pos_ack), 16'd0);
        step(11'(VP), 11'd0, 1'b0);
        chk("ack_up", 16'(pos_ack), 16'd1);
        chk("tick_up", 16'(frame_tick), 16'd1);
        step(11'(VP), 11'd1, 1'b0);
        chk("ack_once", 16'(pos_ack), 16'd0);
        step(11'd50, 11'd107, 1'b1);
        step(11'd61, 11'd103, 1'b1);
        chk("up_barrel", 16'(icon), 16'd2);
        step(11'd61, 11'd105, 1'b1);
        chk("up_tread", 16'(icon), 16'd3);
        step(11'd50, 11'd100, 1'b1);
        chk("up_body", 16'(icon), 16'd1);
        step(11'd66, 11'd107, 1'b1);
        chk("up_corner", 16'(icon), 16'd0);
        step(11'd0, 11'd0, 1'b1);
        chk("up_below", 16'(icon), 16'd0);

        // Heading right, same position.
        request(100, 50, 1);
        step(11'(VP), 11'd0, 1'b0);
        step(11'd57, 11'd115, 1'b1);
        step(11'd50, 11'd107, 1'b1);
        chk("right_barrel", 16'(icon), 16'd2);
        step(11'd0, 11'd0, 1'b1);
        chk("right_empty", 16'(icon), 16'd0);

        // Withdrawn request leaves the active position alone.
        request(300, 300, 2);
        repeat (5) step(11'd20, 11'd20, 1'b1);
        pos_valid = 1'b0;
        step(11'(VP), 11'd0, 1'b0);
        chk("withdrawn_ack", 16'(pos_ack), 16'd0);
        step(11'd57, 11'd115, 1'b1);
        step(11'd0, 11'd0, 1'b1);
        chk("withdrawn_keep", 16'(icon), 16'd2);

        // Bottom-right edge clip, no wrap to row 0 / column 0.
        request(1016, 760, 0);
        step(11'(VP), 11'd0, 1'b0);
        step(11'd767, 11'd1023, 1'b1);
        step(11'd0, 11'd0, 1'b1);
        chk("clip_edge", 16'(icon), 16'd2);
        step(11'd0, 11'd1020, 1'b1);
        chk("clip_origin", 16'(icon), 16'd0);
        step(11'd765, 11'd0, 1'b1);
        chk("clip_row0", 16'(icon), 16'd0);
        step(11'd0, 11'd0, 1'b1);
        chk("clip_col0", 16'(icon), 16'd0);

`ifdef SPRITE_FLASH_EN
        // Blink sequence: sprite at (100, 50) up, hit, then walk 17 frames.
        request(100, 50, 0);
        step(11'(VP), 11'd0, 1'b0);
        hit = 1'b1;
        step(11'd5, 11'd5, 1'b0);
        for (int f = 16; f >= 0; f--) begin
            step(11'd50, 11'd107, 1'b1);
            step(11'd1, 11'd1, 1'b1);
            chk("flash", 16'(icon), (f != 0 && (f % 4) >= 2) ? 16'd0 : 16'd2);
            step(11'(VP), 11'd0, 1'b0);
        end
`else
        // Hit has no effect without the blink feature.
        request(100, 50, 0);
        step(11'(VP), 11'd0, 1'b0);
        hit = 1'b1;
        step(11'd5, 11'd5, 1'b0);
        step(11'(VP), 11'd0, 1'b0);
        step(11'd50, 11'd107, 1'b1);
        step(11'd1, 11'd1, 1'b1);
        chk("hit_ignored", 16'(icon), 16'd2);
`endif

        repeat (12000) rand_step();

        // Reset mid-frame while a request is pending.
        request(200, 200, 3);
        step(11'd300, 11'd300, 1'b1);
        do_reset();
        step(11'd201, 11'd201, 1'b1);
        step(11'd0, 11'd0, 1'b1);
        chk("post_rst_blank", 16'(icon), 16'd0);

        repeat (12000) rand_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
